// File: rtl/lsu_if.sv
// Load/store request, response and DataMemory signal bundle for lsu_ctrl.
// The slave modport is the controller side; master is the pipeline/memory side.
interface lsu_if;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CODE_W = 5;

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_type;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;

    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_exc;
    logic [CODE_W-1:0] resp_exc_code;
    logic [ADDR_W-1:0] resp_badvaddr;

    logic              dm_ren;
    logic              dm_wen;
    logic [1:0]        dm_rwtype;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_sign_extend;
    logic [DATA_W-1:0] dm_rdata;

    modport slave (
        input  req_valid, req_we, req_type, req_unsigned, req_addr, req_wdata, dm_rdata,
        output req_ready, resp_valid, resp_rdata, resp_exc, resp_exc_code, resp_badvaddr,
        output dm_ren, dm_wen, dm_rwtype, dm_addr, dm_wdata, dm_sign_extend
    );

    modport master (
        output req_valid, req_we, req_type, req_unsigned, req_addr, req_wdata, dm_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_exc, resp_exc_code, resp_badvaddr,
        input  dm_ren, dm_wen, dm_rwtype, dm_addr, dm_wdata, dm_sign_extend
    );
endinterface

// File: rtl/lsu_ctrl.sv
// MEM-stage load/store controller: alignment/segment checks, DataMemory sequencing,
// and a single-cycle response carrying load data or a MIPS address-error exception.
module lsu_ctrl #(
    parameter logic [31:0] DM_BASE    = 32'h1001_0000,
    parameter logic [31:0] DM_LIMIT   = 32'h7FFF_FFFF,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic  clk,
    input  logic  rst_n,
    lsu_if.slave  bus
);
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CODE_W = 5;

    localparam logic [CODE_W-1:0] EXC_ADEL = CODE_W'(4);
    localparam logic [CODE_W-1:0] EXC_ADES = CODE_W'(5);
    localparam logic [CODE_W-1:0] EXC_RI   = CODE_W'(10);

    typedef enum logic [1:0] {IDLE, ACCESS, EXC, RESP} state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
    logic                resp_exc_q, resp_exc_d;
    logic [CODE_W-1:0]   resp_code_q, resp_code_d;
    logic [ADDR_W-1:0]   resp_badv_q, resp_badv_d;
    logic                dm_ren_q, dm_ren_d;
    logic                dm_wen_q, dm_wen_d;
    logic [1:0]          dm_rwtype_q, dm_rwtype_d;
    logic [ADDR_W-1:0]   dm_addr_q, dm_addr_d;
    logic [DATA_W-1:0]   dm_wdata_q, dm_wdata_d;
    logic                dm_sext_q, dm_sext_d;

    logic accept;
    logic misaligned;
    logic out_of_range;

    assign bus.req_ready = (state_q == IDLE) & rst_n;
    assign accept        = bus.req_valid & (state_q == IDLE);

    assign misaligned   = ((bus.req_type == 2'b01) && bus.req_addr[0]) ||
                          ((bus.req_type == 2'b10) && (bus.req_addr[1:0] != 2'b00));
    assign out_of_range = (bus.req_addr < DM_BASE) || (bus.req_addr > DM_LIMIT);

    // Next state; the dm_* registers double as the latched request during ACCESS.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = '0;
        resp_exc_d   = 1'b0;
        resp_code_d  = '0;
        resp_badv_d  = '0;
        dm_ren_d     = 1'b0;
        dm_wen_d     = 1'b0;
        dm_rwtype_d  = '0;
        dm_addr_d    = '0;
        dm_wdata_d   = '0;
        dm_sext_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (bus.req_type == 2'b11) begin
                        state_d      = EXC;
                        resp_valid_d = 1'b1;
                        resp_exc_d   = 1'b1;
                        resp_code_d  = EXC_RI;
                        resp_badv_d  = bus.req_addr;
                    end else if (misaligned || out_of_range) begin
                        state_d      = EXC;
                        resp_valid_d = 1'b1;
                        resp_exc_d   = 1'b1;
                        resp_code_d  = bus.req_we ? EXC_ADES : EXC_ADEL;
                        resp_badv_d  = bus.req_addr;
                    end else begin
                        state_d     = ACCESS;
                        dm_ren_d    = ~bus.req_we;
                        dm_wen_d    = bus.req_we;
                        dm_rwtype_d = bus.req_type;
                        dm_addr_d   = bus.req_addr;
                        dm_wdata_d  = bus.req_we ? bus.req_wdata : '0;
                        dm_sext_d   = ~bus.req_unsigned;
                        cnt_d       = bus.req_we ? '0 : CNT_W'(RD_LATENCY - 1);
                    end
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = dm_ren_q ? bus.dm_rdata : '0;
                end else begin
                    cnt_d       = cnt_q - CNT_W'(1);
                    dm_ren_d    = dm_ren_q;
                    dm_wen_d    = dm_wen_q;
                    dm_rwtype_d = dm_rwtype_q;
                    dm_addr_d   = dm_addr_q;
                    dm_wdata_d  = dm_wdata_q;
                    dm_sext_d   = dm_sext_q;
                end
            end
            EXC:     state_d = IDLE;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Reset aborts any in-flight access; no response is ever emitted for it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_exc_q   <= 1'b0;
            resp_code_q  <= '0;
            resp_badv_q  <= '0;
            dm_ren_q     <= 1'b0;
            dm_wen_q     <= 1'b0;
            dm_rwtype_q  <= '0;
            dm_addr_q    <= '0;
            dm_wdata_q   <= '0;
            dm_sext_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_exc_q   <= resp_exc_d;
            resp_code_q  <= resp_code_d;
            resp_badv_q  <= resp_badv_d;
            dm_ren_q     <= dm_ren_d;
            dm_wen_q     <= dm_wen_d;
            dm_rwtype_q  <= dm_rwtype_d;
            dm_addr_q    <= dm_addr_d;
            dm_wdata_q   <= dm_wdata_d;
            dm_sext_q    <= dm_sext_d;
        end
    end

    assign bus.resp_valid     = resp_valid_q;
    assign bus.resp_rdata     = resp_rdata_q;
    assign bus.resp_exc       = resp_exc_q;
    assign bus.resp_exc_code  = resp_code_q;
    assign bus.resp_badvaddr  = resp_badv_q;
    assign bus.dm_ren         = dm_ren_q;
    assign bus.dm_wen         = dm_wen_q;
    assign bus.dm_rwtype      = dm_rwtype_q;
    assign bus.dm_addr        = dm_addr_q;
    assign bus.dm_wdata       = dm_wdata_q;
    assign bus.dm_sign_extend = dm_sext_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench: two lsu_ctrl instances (RD_LATENCY 1 and 3) share directed stimulus;
// a negedge monitor checks responses, latencies and DataMemory activity against the queue.
module tb_lsu_ctrl;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        req_valid    = 1'b0;
    logic        req_we       = 1'b0;
    logic [1:0]  req_type     = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr     = 32'h0;
    logic [31:0] req_wdata    = 32'h0;
    logic        force_en     = 1'b0;
    logic [31:0] force_val    = 32'h0;

    logic [31:0] mem [2][16];

    logic        m_ready [2];
    logic        m_rv    [2];
    logic        m_exc   [2];
    logic [4:0]  m_code  [2];
    logic [31:0] m_rdata [2];
    logic [31:0] m_badv  [2];
    logic        m_ren   [2];
    logic        m_wen   [2];
    logic [1:0]  m_rwt   [2];
    logic [31:0] m_addr  [2];
    logic [31:0] m_wdata [2];
    logic        m_sext  [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        lsu_if bus ();
        assign bus.req_valid    = req_valid;
        assign bus.req_we       = req_we;
        assign bus.req_type     = req_type;
        assign bus.req_unsigned = req_unsigned;
        assign bus.req_addr     = req_addr;
        assign bus.req_wdata    = req_wdata;
        assign bus.dm_rdata     = force_en ? force_val : mem[g][bus.dm_addr[5:2]];

        lsu_ctrl #(
            .DM_BASE    (32'h1001_0000),
            .DM_LIMIT   (32'h7FFF_FFFF),
            .RD_LATENCY ((g == 0) ? 1 : 3)
        ) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );

        assign m_ready[g] = bus.req_ready;
        assign m_rv[g]    = bus.resp_valid;
        assign m_exc[g]   = bus.resp_exc;
        assign m_code[g]  = bus.resp_exc_code;
        assign m_rdata[g] = bus.resp_rdata;
        assign m_badv[g]  = bus.resp_badvaddr;
        assign m_ren[g]   = bus.dm_ren;
        assign m_wen[g]   = bus.dm_wen;
        assign m_rwt[g]   = bus.dm_rwtype;
        assign m_addr[g]  = bus.dm_addr;
        assign m_wdata[g] = bus.dm_wdata;
        assign m_sext[g]  = bus.dm_sign_extend;
    end

    typedef struct {
        logic        abort;
        logic [4:0]  code;
        logic [31:0] rdata;
        logic [31:0] badv;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  rwt;
        logic        sext;
        int          acc;
        int          lat;
        int          rdy_low;
        int          ren_n;
        int          wen_n;
    } exp_t;

    exp_t exp_q [2][$];

    int tests   = 0;
    int fails   = 0;
    int to_req  = 0;
    int to_seen = 0;
    int cyc     = 0;

    int          rdy_low   [2];
    int          ren_n     [2];
    int          wen_n     [2];
    logic [31:0] cap_addr  [2];
    logic [31:0] cap_wdata [2];
    logic [1:0]  cap_rwt   [2];
    logic        cap_sext  [2];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input int k, input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s dut%0d @cyc %0d: got 0x%08h, want 0x%08h", name, k, cyc, act, exp);
        end
    endtask

    task automatic clear_obs(input int k);
        rdy_low[k]   = 0;
        ren_n[k]     = 0;
        wen_n[k]     = 0;
        cap_addr[k]  = '0;
        cap_wdata[k] = '0;
        cap_rwt[k]   = '0;
        cap_sext[k]  = 1'b0;
    endtask

    // Monitor: memory model, quiet-bus rules, and response scoreboard per instance.
    always @(negedge clk) begin
        if (to_req != to_seen) begin
            tests++;
            fails++;
            $display("FAIL driver_timeout: got %0d expired waits, want 0", to_req - to_seen);
            to_seen = to_req;
        end
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                check(k, "reset_ctrl", {20'h0, m_ready[k], m_rv[k], m_exc[k], m_ren[k],
                                        m_wen[k], m_sext[k], m_code[k], m_rwt[k]}, 32'h0);
                check(k, "reset_data", m_rdata[k] | m_badv[k] | m_addr[k] | m_wdata[k], 32'h0);
                if (exp_q[k].size() > 0 && exp_q[k][0].abort) void'(exp_q[k].pop_front());
                clear_obs(k);
            end else begin
                if (m_wen[k]) mem[k][m_addr[k][5:2]] = m_wdata[k];
                if (!m_rv[k])
                    check(k, "resp_quiet", m_rdata[k] | m_badv[k] | {26'h0, m_exc[k], m_code[k]}, 32'h0);
                if (!m_ren[k] && !m_wen[k])
                    check(k, "dm_quiet", m_addr[k] | m_wdata[k] | {29'h0, m_rwt[k], m_sext[k]}, 32'h0);
                if (exp_q[k].size() == 0) begin
                    check(k, "idle_ready", 32'(m_ready[k]), 32'h1);
                    check(k, "unexpected_resp", 32'(m_rv[k]), 32'h0);
                    check(k, "idle_dm", {30'h0, m_ren[k], m_wen[k]}, 32'h0);
                end else begin
                    exp_t e;
                    e = exp_q[k][0];
                    if (!m_ready[k]) rdy_low[k]++;
                    if (m_ren[k] || m_wen[k]) begin
                        if (m_ren[k]) ren_n[k]++;
                        if (m_wen[k]) wen_n[k]++;
                        cap_addr[k]  = m_addr[k];
                        cap_wdata[k] = m_wdata[k];
                        cap_rwt[k]   = m_rwt[k];
                        cap_sext[k]  = m_sext[k];
                    end
                    if (e.abort) begin
                        check(k, "abort_no_resp", 32'(m_rv[k]), 32'h0);
                    end else if (m_rv[k]) begin
                        check(k, "latency", 32'(cyc - e.acc), 32'(e.lat));
                        check(k, "resp_exc", 32'(m_exc[k]), 32'(e.code != 5'd0));
                        check(k, "resp_code", 32'(m_code[k]), 32'(e.code));
                        check(k, "resp_rdata", m_rdata[k], e.rdata);
                        check(k, "resp_badvaddr", m_badv[k], e.badv);
                        check(k, "ready_low_cycles", 32'(rdy_low[k]), 32'(e.rdy_low));
                        check(k, "dm_ren_cycles", 32'(ren_n[k]), 32'(e.ren_n));
                        check(k, "dm_wen_cycles", 32'(wen_n[k]), 32'(e.wen_n));
                        if (e.ren_n + e.wen_n > 0) begin
                            check(k, "dm_addr", cap_addr[k], e.addr);
                            check(k, "dm_wdata", cap_wdata[k], e.wdata);
                            check(k, "dm_rwtype", 32'(cap_rwt[k]), 32'(e.rwt));
                            check(k, "dm_sign_extend", 32'(cap_sext[k]), 32'(e.sext));
                        end
                        void'(exp_q[k].pop_front());
                        clear_obs(k);
                    end else if ((cyc - e.acc) > e.lat) begin
                        check(k, "resp_timeout", 32'(cyc - e.acc), 32'(e.lat));
                        void'(exp_q[k].pop_front());
                        clear_obs(k);
                    end
                end
            end
        end
    end

    // Wait for both instances idle, present one request, push the hand-computed responses.
    task automatic issue(input logic we, input logic [1:0] ty, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic fen, input logic [31:0] fval,
                         input logic [4:0] code, input logic [31:0] rdata, input logic abort);
        int n;
        n = 0;
        @(negedge clk);
        while (!(m_ready[0] && m_ready[1]) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            to_req++;
            return;
        end
        req_we       = we;
        req_type     = ty;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        force_en     = fen;
        force_val    = fval;
        req_valid    = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            exp_t e;
            int   lat_rd;
            lat_rd    = (k == 0) ? 1 : 3;
            e.abort   = abort;
            e.code    = code;
            e.rdata   = rdata;
            e.badv    = (code != 5'd0) ? addr : 32'h0;
            e.addr    = addr;
            e.wdata   = we ? wdata : 32'h0;
            e.rwt     = ty;
            e.sext    = ~uns;
            e.acc     = cyc;
            e.lat     = (code != 5'd0) ? 0 : (we ? 1 : lat_rd);
            e.rdy_low = e.lat + 1;
            e.ren_n   = (code == 5'd0 && !we) ? lat_rd : 0;
            e.wen_n   = (code == 5'd0 && we) ? 1 : 0;
            exp_q[k].push_back(e);
        end
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;

        //     we    ty     uns   addr           wdata          fen   fval           code   rdata          abort
        issue(1'b1, 2'b10, 1'b0, 32'h1001_0004, 32'hDEAD_BEEF, 1'b0, 32'h0,         5'd0,  32'h0,         1'b0);
        issue(1'b0, 2'b10, 1'b0, 32'h1001_0004, 32'h0,         1'b0, 32'h0,         5'd0,  32'hDEAD_BEEF, 1'b0);
        issue(1'b0, 2'b00, 1'b0, 32'h1001_0007, 32'h0,         1'b1, 32'hFFFF_FF80, 5'd0,  32'hFFFF_FF80, 1'b0);
        issue(1'b0, 2'b00, 1'b1, 32'h1001_0007, 32'h0,         1'b1, 32'h0000_0080, 5'd0,  32'h0000_0080, 1'b0);
        issue(1'b0, 2'b01, 1'b0, 32'h1001_0001, 32'h0,         1'b0, 32'h0,         5'd4,  32'h0,         1'b0);
        issue(1'b1, 2'b10, 1'b0, 32'h0000_1000, 32'h1111_2222, 1'b0, 32'h0,         5'd5,  32'h0,         1'b0);
        issue(1'b0, 2'b11, 1'b0, 32'h1001_0000, 32'h0,         1'b0, 32'h0,         5'd10, 32'h0,         1'b0);
        issue(1'b1, 2'b11, 1'b0, 32'h0000_0003, 32'h5555_AAAA, 1'b0, 32'h0,         5'd10, 32'h0,         1'b0);
        issue(1'b0, 2'b10, 1'b0, 32'h1000_FFFC, 32'h0,         1'b0, 32'h0,         5'd4,  32'h0,         1'b0);
        issue(1'b0, 2'b10, 1'b0, 32'h1001_0000, 32'h0,         1'b1, 32'hCAFE_F00D, 5'd0,  32'hCAFE_F00D, 1'b0);
        issue(1'b0, 2'b10, 1'b0, 32'h7FFF_FFFC, 32'h0,         1'b1, 32'h1357_2468, 5'd0,  32'h1357_2468, 1'b0);
        issue(1'b0, 2'b00, 1'b0, 32'h7FFF_FFFF, 32'h0,         1'b1, 32'h0000_0011, 5'd0,  32'h0000_0011, 1'b0);
        issue(1'b1, 2'b00, 1'b0, 32'h8000_0000, 32'h0000_00AB, 1'b0, 32'h0,         5'd5,  32'h0,         1'b0);
        issue(1'b0, 2'b01, 1'b0, 32'h1001_0003, 32'h0,         1'b0, 32'h0,         5'd4,  32'h0,         1'b0);
        issue(1'b0, 2'b10, 1'b0, 32'h1001_0002, 32'h0,         1'b0, 32'h0,         5'd4,  32'h0,         1'b0);
        issue(1'b1, 2'b01, 1'b0, 32'h1001_0002, 32'h0000_1234, 1'b0, 32'h0,         5'd0,  32'h0,         1'b0);

        // A request raised while busy must be ignored.
        @(negedge clk);
        req_type  = 2'b11;
        req_addr  = 32'h0000_0001;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;

        // Reset during the store's ACCESS cycle aborts it.
        issue(1'b1, 2'b10, 1'b0, 32'h1001_0008, 32'h0BAD_0BAD, 1'b0, 32'h0,         5'd0,  32'h0,         1'b1);
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;

        issue(1'b1, 2'b10, 1'b0, 32'h1001_000C, 32'h0C0F_FEE0, 1'b0, 32'h0,         5'd0,  32'h0,         1'b0);
        issue(1'b0, 2'b10, 1'b1, 32'h1001_000C, 32'h0,         1'b0, 32'h0,         5'd0,  32'h0C0F_FEE0, 1'b0);

        n = 0;
        while ((exp_q[0].size() != 0 || exp_q[1].size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) to_req++;
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
